// File: rtl/cam_pixel_sequencer_if.sv
// ----------------------------------------------------------------------------
// cam_pixel_sequencer_if : camera byte port, sample stream and status bundle
// Optional: CAM_SEQ_STATS_EN adds frame_count/drop_count.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cam_pixel_sequencer_if;
  logic       capture_en;
  logic       continuous;
  logic       cam_vsync;
  logic       cam_href;
  logic       cam_byte_valid;
  logic [7:0] cam_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] data;
  logic [9:0] row;
  logic [9:0] col;
  logic [1:0] YUV;
  logic       frame_done;
  logic       overflow;
  logic       line_err;
  logic       busy;
`ifdef CAM_SEQ_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif

  modport master (
`ifdef CAM_SEQ_STATS_EN
    output frame_count, drop_count,
`endif
    input  capture_en, continuous, cam_vsync, cam_href, cam_byte_valid, cam_data, out_ready,
    output out_valid, data, row, col, YUV, frame_done, overflow, line_err, busy
  );

  modport slave (
`ifdef CAM_SEQ_STATS_EN
    input  frame_count, drop_count,
`endif
    output capture_en, continuous, cam_vsync, cam_href, cam_byte_valid, cam_data, out_ready,
    input  out_valid, data, row, col, YUV, frame_done, overflow, line_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/cam_pixel_sequencer.sv
// ----------------------------------------------------------------------------
// cam_pixel_sequencer : frames YUYV camera bytes into row/col/plane samples
// Optional: CAM_SEQ_STATS_EN adds frame and drop counters.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_pixel_sequencer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cam_pixel_sequencer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(2 * H_ACTIVE + 1);
  localparam logic [BW-1:0] LINE_BYTES = BW'(2 * H_ACTIVE);
  localparam logic [9:0]    ROWS       = 10'(V_ACTIVE);
  localparam logic [CW-1:0] DEPTH      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_VS   = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_LINE      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] row;
    logic [9:0] col;
    logic [1:0] yuv;
  } sample_t;

  state_t        state_q, state_d;
  logic [9:0]    row_q, row_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          line_err_q, line_err_d;
  logic          frame_done_q, frame_done_d;
  logic          vs_q, vs_prev_q, href_q, href_prev_q;

  sample_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic    w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
  logic    w_byte, w_in_range, w_take, w_gen, w_extra;
  logic    w_pop, w_full, w_push, w_drop;
  sample_t w_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
    end else begin
      vs_q        <= bus.cam_vsync;
      vs_prev_q   <= vs_q;
      href_q      <= bus.cam_href;
      href_prev_q <= href_q;
    end
  end

  assign w_vs_rise   =  vs_q & ~vs_prev_q;
  assign w_vs_fall   = ~vs_q &  vs_prev_q;
  assign w_href_rise =  href_q & ~href_prev_q;
  assign w_href_fall = ~href_q &  href_prev_q;

  // Line counters are cleared at line end, so a byte arriving with the raw
  // HREF rise (before the registered edge is seen) is taken as byte 0.
  assign w_byte     = bus.cam_byte_valid & bus.cam_href;
  assign w_in_range = (row_q < ROWS);
  assign w_take     = w_byte && w_in_range && !w_vs_rise &&
                      ((state_q == S_LINE && !w_href_fall) ||
                       (state_q == S_WAIT_LINE && !href_prev_q));
  assign w_gen      = w_take && (cnt_q != LINE_BYTES);
  assign w_extra    = w_take && (cnt_q == LINE_BYTES);

  assign w_pop  = (count_q != '0) && bus.out_ready;
  assign w_full = (count_q == DEPTH);
  assign w_push = w_gen && (!w_full || w_pop);
  assign w_drop = w_gen && w_full && !w_pop;

  always_comb begin
    w_sample.data = bus.cam_data;
    w_sample.row  = row_q;
    w_sample.yuv  = (cnt_q[1:0] == 2'd1) ? 2'b01 :
                    (cnt_q[1:0] == 2'd3) ? 2'b10 : 2'b00;
    w_sample.col  = cnt_q[0] ? 10'(cnt_q >> 2) : 10'(cnt_q >> 1);
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    overflow_d   = overflow_q;
    line_err_d   = line_err_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.capture_en) begin
          overflow_d = 1'b0;
          line_err_d = 1'b0;
          state_d    = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        if (w_vs_fall) begin
          row_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if (w_vs_rise)        state_d = S_DONE;
        else if (w_href_rise) state_d = S_LINE;
      end
      S_LINE: begin
        if (w_vs_rise) begin
          line_err_d = 1'b1;
          state_d    = S_DONE;
        end else if (w_href_fall) begin
          if (w_in_range) begin
            if (cnt_q != LINE_BYTES) line_err_d = 1'b1;
            row_d = row_q + 10'd1;
          end
          cnt_d   = '0;
          state_d = S_WAIT_LINE;
        end
      end
      S_DONE: begin
        if (count_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = bus.continuous ? S_WAIT_VS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Tag counters advance on every in-line byte, dropped or not.
    if (w_gen)   cnt_d      = cnt_q + 1'b1;
    if (w_extra) line_err_d = 1'b1;
    if (w_drop)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      line_err_q   <= line_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_sample;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_q <= count_q + 1'b1;
      else if (!w_push && w_pop) count_q <= count_q - 1'b1;
    end
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.data       = mem_q[rd_ptr_q].data;
  assign bus.row        = mem_q[rd_ptr_q].row;
  assign bus.col        = mem_q[rd_ptr_q].col;
  assign bus.YUV        = mem_q[rd_ptr_q].yuv;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.line_err   = line_err_q;
  assign bus.busy       = (state_q != S_IDLE);

`ifdef CAM_SEQ_STATS_EN
  logic [15:0] frame_count_q, drop_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (frame_done_d) frame_count_q <= frame_count_q + 16'd1;
      if (w_drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;
`else
  // Statistics counters not built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_pixel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cam_pixel_sequencer : random-timed YUYV frames against a sample-queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cam_pixel_sequencer;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int D  = 4;
  localparam int NL = 7;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] r;
    logic [9:0] c;
    logic [1:0] p;
  } samp_t;

  logic clk;
  logic reset;
  cam_pixel_sequencer_if bus();

  cam_pixel_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errs   = 0;
  samp_t mq[$];
  samp_t m_samp;
  bit    m_push, m_cap, exp_ovf, exp_lerr, rdy_rand, cont;
  int    fd_cnt, hold_n, m_frames, m_drops;
  int    line_len[NL];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.out_valid, bus.frame_done, bus.overflow, bus.line_err, bus.busy,
                bus.data, bus.row, bus.col, bus.YUV});
  endfunction

  // One clock: the model FIFO pops/pushes as the spec says, then the head is compared.
  task automatic tick();
    bit pop;
    if (hold_n > 0) begin
      bus.out_ready = 1'b0;
      hold_n--;
    end else begin
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    @(posedge clk);
    pop = (mq.size() != 0) && bus.out_ready;
    if (pop) void'(mq.pop_front());
    if (m_push) begin
      if (mq.size() < D) mq.push_back(m_samp);
      else begin
        exp_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    m_push = 1'b0;
    #1;
    chk_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0)
      chk_eq("head_sample", 64'({bus.data, bus.row, bus.col, bus.YUV}), 64'(mq[0]));
    if (bus.frame_done) fd_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input int r, input int b);
    samp_t s;
    s.d = 8'($urandom);
    s.r = 10'(r);
    case (b % 4)
      0:       begin s.p = 2'b00; s.c = 10'(b / 2); end
      1:       begin s.p = 2'b01; s.c = 10'(b / 4); end
      2:       begin s.p = 2'b00; s.c = 10'(b / 2); end
      default: begin s.p = 2'b10; s.c = 10'(b / 4); end
    endcase
    bus.cam_data       = s.d;
    bus.cam_byte_valid = 1'b1;
    m_samp = s;
    m_push = m_cap && (r < V) && (b < 2 * H);
    tick();
    bus.cam_byte_valid = 1'b0;
  endtask

  task automatic arm(input bit c);
    cont           = c;
    bus.continuous = c;
    bus.capture_en = 1'b1;
    exp_ovf  = 1'b0;
    exp_lerr = 1'b0;
    m_cap    = 1'b1;
    tick();
    bus.capture_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_eq("reset_async", outs(), 64'd0);
    @(posedge clk);
    #1;
    chk_eq("reset_held", outs(), 64'd0);
    reset = 1'b0;
    mq.delete();
    m_cap    = 1'b0;
    exp_ovf  = 1'b0;
    exp_lerr = 1'b0;
    m_frames = 0;
    m_drops  = 0;
    hold_n   = 0;
`ifdef CAM_SEQ_STATS_EN
    chk_eq("frame_count_reset", 64'(bus.frame_count), 64'd0);
`endif
  endtask

  task automatic run_frame(input int early_row, input int reset_row, input bit gaps,
                           input int hold_line, input int hold_cycles);
    bit stop = 1'b0;
    bit rst_hit = 1'b0;
    fd_cnt = 0;
    bus.cam_vsync = 1'b1;
    idle(4);
    bus.cam_vsync = 1'b0;
    idle(4);
    for (int r = 0; r < NL && !stop; r++) begin
      if (r == hold_line) hold_n = hold_cycles;
      bus.cam_href = 1'b1;
      for (int b = 0; b < line_len[r] && !stop; b++) begin
        if (r == early_row && b == line_len[r] / 2) begin
          bus.cam_vsync = 1'b1;
          idle(3);
          exp_lerr = 1'b1;
          stop     = 1'b1;
        end else if (r == reset_row && b == 5) begin
          do_reset();
          stop    = 1'b1;
          rst_hit = 1'b1;
        end else begin
          if (gaps && b > 0) idle(int'($urandom_range(0, 1)));
          send_byte(r, b);
        end
      end
      bus.cam_href = 1'b0;
      idle(4);
      if (!stop && r < V && line_len[r] != 2 * H) exp_lerr = 1'b1;
    end
    bus.cam_vsync = 1'b1;
    if (!rst_hit) begin
      for (int i = 0; i < 300 && fd_cnt == 0; i++) tick();
      idle(3);
      chk_eq("frame_done_pulses", 64'(fd_cnt), 64'd1);
      chk_eq("overflow", 64'(bus.overflow), 64'(exp_ovf));
      chk_eq("line_err", 64'(bus.line_err), 64'(exp_lerr));
      chk_eq("busy_after_frame", 64'(bus.busy), 64'(cont));
      m_frames += fd_cnt;
    end else begin
      idle(3);
      chk_eq("busy_after_reset", 64'(bus.busy), 64'd0);
      chk_eq("no_frame_done", 64'(fd_cnt), 64'd0);
    end
`ifdef CAM_SEQ_STATS_EN
    chk_eq("frame_count", 64'(bus.frame_count), 64'(m_frames));
    chk_eq("drop_count", 64'(bus.drop_count), 64'(m_drops));
`endif
  endtask

  initial begin
    reset              = 1'b1;
    bus.capture_en     = 1'b0;
    bus.continuous     = 1'b0;
    bus.cam_vsync      = 1'b1;
    bus.cam_href       = 1'b0;
    bus.cam_byte_valid = 1'b0;
    bus.cam_data       = 8'h00;
    bus.out_ready      = 1'b1;
    m_push = 1'b0; m_cap = 1'b0; exp_ovf = 1'b0; exp_lerr = 1'b0;
    rdy_rand = 1'b0; cont = 1'b0;
    fd_cnt = 0; hold_n = 0; m_frames = 0; m_drops = 0;
    for (int i = 0; i < NL; i++) line_len[i] = (i < V) ? 2 * H : 5;

    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_state", outs(), 64'd0);
    reset = 1'b0;
    idle(2);

    // Nominal frame, full throughput, continuous re-arm; extra row beyond V dropped.
    arm(1'b1);
    run_frame(-1, -1, 1'b0, -1, 0);

    // Re-armed frame with a short and a long line, random gaps and random ready.
    cont           = 1'b0;
    bus.continuous = 1'b0;
    line_len[2]    = 2 * H - 2;
    line_len[4]    = 2 * H + 2;
    rdy_rand       = 1'b1;
    run_frame(-1, -1, 1'b1, -1, 0);
    line_len[2] = 2 * H;
    line_len[4] = 2 * H;
    rdy_rand    = 1'b0;

    // Backpressure: ready held low while bytes keep arriving.
    arm(1'b0);
    run_frame(-1, -1, 1'b0, 1, 10);

    // FIFO fills, then push and pop coincide.
    arm(1'b0);
    run_frame(-1, -1, 1'b0, 0, D);

    // Early VSYNC in the middle of row 3.
    arm(1'b0);
    rdy_rand = 1'b1;
    run_frame(3, -1, 1'b1, -1, 0);

    // Reset mid-line, then a fresh capture.
    arm(1'b0);
    run_frame(-1, 1, 1'b0, -1, 0);
    arm(1'b0);
    run_frame(-1, -1, 1'b1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
